// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and 8N1 frame constants,
// used by both the receive and transmit ends of the serial link.
package uart_pkg;

    // Common state encoding for the UART FSMs
    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] START = 2'b01;
    localparam logic [1:0] DATA  = 2'b10;
    localparam logic [1:0] STOP  = 2'b11;

    // Frame format: 8 data bits, one stop bit at line level 1
    localparam int   DATA_BITS  = 8;
    localparam logic STOP_LEVEL = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE  = IDLE,
        S_START = START,
        S_DATA  = DATA,
        S_STOP  = STOP
    } uart_state_e;

endpackage : uart_pkg

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for asynchronous inputs. Both stages reset to
// RESET_VAL so an idle-high line does not look like an edge after reset.
module uart_rx_sync #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two back-to-back capture stages to settle metastability
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule : uart_rx_sync

// File: rtl/uart_rx.sv
// 8N1 UART receiver. Detects the start edge on the synchronized line,
// samples each bit at mid-period, and reports either a good byte (valid)
// or a bad stop bit (frame_err) with a one-cycle pulse.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CW       = $clog2(CLKS_PER_BIT);
    localparam int BW       = $clog2(DATA_BITS);

    logic                 rx_s;
    logic                 rx_p_q;
    uart_state_e          state_q;
    logic [CW-1:0]        cnt_q;
    logic [BW-1:0]        bit_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 frame_err_q;
    logic                 busy_q;

    uart_rx_sync #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk     (clk),
        .reset   (reset),
        .async_i (rx),
        .sync_o  (rx_s)
    );

    // Previous synchronized sample, used for falling-edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_p_q <= 1'b1;
        end else begin
            rx_p_q <= rx_s;
        end
    end

    // Receive FSM: start validation, data sampling, stop check, pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // Only a genuine 1->0 transition starts a frame, so a
                    // line stuck low (break) cannot retrigger
                    if (rx_p_q && !rx_s) begin
                        state_q <= S_START;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_START: begin
                    if (cnt_q == CW'(HALF_BIT - 1)) begin
                        if (!rx_s) begin
                            state_q   <= S_DATA;
                            cnt_q     <= '0;
                            bit_idx_q <= '0;
                        end else begin
                            // Line went back high before mid-bit: glitch
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_DATA: begin
                    if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                        cnt_q     <= '0;
                        shift_q   <= {rx_s, shift_q[DATA_BITS-1:1]};
                        bit_idx_q <= bit_idx_q + BW'(1);
                        if (bit_idx_q == BW'(DATA_BITS - 1)) begin
                            state_q <= S_STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_STOP: begin
                    if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                        // Return to IDLE at mid stop bit so a back-to-back
                        // start edge right after it is not missed
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                        if (rx_s == STOP_LEVEL) begin
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: a serial transmitter model drives frames, expected
// results go into a scoreboard queue, and a monitor checks every pulse.
module tb_uart_rx;

    localparam int CPB = 16;
    // Drive cycle of start bit -> pulse cycle: 2 sync + half bit + 9 bits + 1
    localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       rx    = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        bit         chk_cyc;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    int         total = 0;
    int         bad   = 0;
    logic [7:0] model_data = 8'h00;
    int         busy_lo = 0;
    int         busy_hi = 0;
    bit         busy_chk = 1'b0;
    bit         busy_ok  = 1'b1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every valid/frame_err pulse with the scoreboard
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset && (valid || frame_err)) begin
            check("pulse_exclusive", int'(valid & frame_err), 0);
            if (sb.size() == 0) begin
                check("unexpected_pulse", valid ? 1 : 2, 0);
            end else begin
                e = sb.pop_front();
                $display("[%0d] received %s data=%02h", cyc, valid ? "byte" : "frame error", data);
                check("pulse_kind", int'(frame_err), int'(e.is_err));
                check("data", int'(data), int'(e.data));
                if (e.chk_cyc) check("pulse_cycle", cyc, e.cyc);
            end
        end
        if (busy_chk) begin
            if (cyc == busy_lo - 1) check("busy_before_start", int'(busy), 0);
            if (cyc >= busy_lo && cyc <= busy_hi && busy !== 1'b1) busy_ok = 1'b0;
            if (cyc == busy_hi + 1) begin
                check("busy_window", int'(busy_ok), 1);
                check("busy_after_frame", int'(busy), 0);
                busy_chk = 1'b0;
            end
        end
    end

    // Hold the line at a level for n cycles
    task automatic hold(input logic lvl, input int n);
        for (int i = 0; i < n; i++) begin
            rx = lvl;
            @(posedge clk);
            #1;
        end
    endtask

    // Drive the first nbits line levels; bit period is p2/2 cycles
    task automatic drive(input logic [9:0] lv, input int p2, input int nbits);
        int c;
        c = 0;
        for (int i = 0; i < nbits; i++) begin
            while (c < ((i + 1) * p2) / 2) begin
                rx = lv[i];
                @(posedge clk);
                #1;
                c++;
            end
        end
    endtask

    // Send one full frame and record the expected outcome
    task automatic send(input logic [7:0] b, input bit stop, input int p2, input bit chk);
        exp_t e;
        if (stop) model_data = b;
        e.is_err  = !stop;
        e.data    = model_data;
        e.chk_cyc = chk;
        e.cyc     = cyc + LAT;
        sb.push_back(e);
        $display("[%0d] send %02h stop=%0d period=%0d/2", cyc, b, stop, p2);
        drive({stop, b, 1'b0}, p2, 10);
    endtask

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation did not finish (actual=timeout required=finish)");
        $fatal(1);
    end

    initial begin : stim
        logic [7:0] b;
        int         p2;
        rx    = 1'b1;
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("reset_data", int'(data), 0);
        check("reset_valid", int'(valid), 0);
        check("reset_frame_err", int'(frame_err), 0);
        check("reset_busy", int'(busy), 0);
        reset = 1'b0;
        hold(1'b1, 20);

        // Ideal single frame with busy window tracking
        busy_lo  = cyc + 3;
        busy_hi  = cyc + LAT - 1;
        busy_ok  = 1'b1;
        busy_chk = 1'b1;
        send(8'hA5, 1'b1, 2 * CPB, 1'b1);
        hold(1'b1, 20);

        // Back-to-back frames
        send(8'h00, 1'b1, 2 * CPB, 1'b1);
        send(8'hFF, 1'b1, 2 * CPB, 1'b1);
        hold(1'b1, 20);

        // Framing error followed by a long break, then a good frame
        send(8'h3C, 1'b0, 2 * CPB, 1'b1);
        hold(1'b0, 40 * CPB);
        hold(1'b1, 2 * CPB);
        send(8'h12, 1'b1, 2 * CPB, 1'b1);
        hold(1'b1, 20);

        // Short low glitch while idle
        hold(1'b0, 3);
        hold(1'b1, 40);
        check("glitch_busy", int'(busy), 0);
        check("glitch_data", int'(data), int'(model_data));

        // Reset in the middle of a frame
        drive({1'b1, 8'h5A, 1'b0}, 2 * CPB, 5);
        reset = 1'b1;
        rx    = 1'b1;
        @(posedge clk);
        #1;
        check("midreset_data", int'(data), 0);
        check("midreset_valid", int'(valid), 0);
        check("midreset_frame_err", int'(frame_err), 0);
        check("midreset_busy", int'(busy), 0);
        reset      = 1'b0;
        model_data = 8'h00;
        hold(1'b1, 10);
        send(8'hC3, 1'b1, 2 * CPB, 1'b1);
        hold(1'b1, 20);

        // Random bytes with transmitter bit period skewed by about 3%
        for (int i = 0; i < 100; i++) begin
            b  = 8'($urandom);
            p2 = 2 * CPB - 1 + int'($urandom_range(0, 2));
            send(b, 1'b1, p2, 1'b0);
            hold(1'b1, int'($urandom_range(0, 3)));
        end

        for (int i = 0; i < 400 && sb.size() != 0; i++) @(posedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_uart_rx
